// File: rtl/crc_16_tx_framer.sv
// Serial frame transmitter: takes one DATA_W-bit word, shifts it out MSB-first,
// then appends its 16-bit CRC (non-reflected, no output XOR) MSB-first.
module crc_16_tx_framer #(
  parameter int          DATA_W   = 32,
  parameter logic [15:0] CRC_POLY = 16'h8005,
  parameter logic [15:0] CRC_INIT = 16'h0000
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic              valid_i,
  output logic              ready_o,
  output logic              ser_o,
  output logic              ser_valid_o,
  output logic              sof_o,
  output logic              eof_o,
  output logic [15:0]       crc_o,
  output logic [1:0]        dbg_state_o
);

  localparam int CNT_MAX = (DATA_W > 16) ? DATA_W : 16;
  localparam int CNT_W   = $clog2(CNT_MAX);
  localparam logic [CNT_W-1:0] LAST_DATA   = CNT_W'(DATA_W - 1);
  localparam logic [CNT_W-1:0] LAST_CRC    = CNT_W'(15);
  localparam logic [CNT_W-1:0] LAST_CRC_M1 = CNT_W'(14);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_DATA = 2'd1,
    S_CRC  = 2'd2
  } state_t;

  state_t             r_state;
  logic [DATA_W-1:0]  r_shift;
  logic [15:0]        r_crc;
  logic [15:0]        r_crc_sh;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_ser;
  logic               r_ser_valid;
  logic               r_sof;
  logic               r_eof;
  logic [15:0]        r_crc_out;

  state_t             w_state;
  logic [DATA_W-1:0]  w_shift;
  logic [15:0]        w_crc;
  logic [15:0]        w_crc_sh;
  logic [CNT_W-1:0]   w_cnt;
  logic               w_ser;
  logic               w_ser_valid;
  logic               w_sof;
  logic               w_eof;
  logic [15:0]        w_crc_out;

  logic               w_fb;
  logic [15:0]        w_crc_step;
  logic [DATA_W-1:0]  w_shift_nx;

  // Handshake: a word is taken on a rising edge where valid_i and ready_o are both
  // high; ready_o is a pure decode of the state register, so it never depends on valid_i.
  assign ready_o     = (r_state == S_IDLE);
  assign ser_o       = r_ser;
  assign ser_valid_o = r_ser_valid;
  assign sof_o       = r_sof;
  assign eof_o       = r_eof;
  assign crc_o       = r_crc_out;
  assign dbg_state_o = r_state;

  // The bit on the wire this cycle is r_shift's MSB; fold it in as it leaves.
  assign w_fb       = r_shift[DATA_W-1] ^ r_crc[15];
  assign w_crc_step = {r_crc[14:0], 1'b0} ^ (w_fb ? CRC_POLY : 16'h0000);
  assign w_shift_nx = r_shift << 1;

  always_comb begin
    w_state     = r_state;
    w_shift     = r_shift;
    w_crc       = r_crc;
    w_crc_sh    = r_crc_sh;
    w_cnt       = r_cnt;
    w_ser       = r_ser;
    w_ser_valid = r_ser_valid;
    w_sof       = 1'b0;
    w_eof       = 1'b0;
    w_crc_out   = r_crc_out;
    case (r_state)
      S_IDLE: begin
        if (valid_i) begin
          w_state     = S_DATA;
          w_shift     = data_i;
          w_crc       = CRC_INIT;
          w_cnt       = '0;
          w_ser       = data_i[DATA_W-1];
          w_ser_valid = 1'b1;
          w_sof       = 1'b1;
        end
      end
      S_DATA: begin
        w_crc   = w_crc_step;
        w_shift = w_shift_nx;
        if (r_cnt == LAST_DATA) begin
          w_state   = S_CRC;
          w_cnt     = '0;
          w_crc_out = w_crc_step;
          w_crc_sh  = w_crc_step;
          w_ser     = w_crc_step[15];
        end else begin
          w_cnt = r_cnt + CNT_W'(1);
          w_ser = w_shift_nx[DATA_W-1];
        end
      end
      S_CRC: begin
        w_crc_sh = {r_crc_sh[14:0], 1'b0};
        if (r_cnt == LAST_CRC) begin
          w_state     = S_IDLE;
          w_cnt       = '0;
          w_ser       = 1'b0;
          w_ser_valid = 1'b0;
        end else begin
          w_cnt = r_cnt + CNT_W'(1);
          w_ser = r_crc_sh[14];
          w_eof = (r_cnt == LAST_CRC_M1);
        end
      end
      default: w_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_state     <= S_IDLE;
      r_shift     <= '0;
      r_crc       <= '0;
      r_crc_sh    <= '0;
      r_cnt       <= '0;
      r_ser       <= 1'b0;
      r_ser_valid <= 1'b0;
      r_sof       <= 1'b0;
      r_eof       <= 1'b0;
      r_crc_out   <= '0;
    end else begin
      r_state     <= w_state;
      r_shift     <= w_shift;
      r_crc       <= w_crc;
      r_crc_sh    <= w_crc_sh;
      r_cnt       <= w_cnt;
      r_ser       <= w_ser;
      r_ser_valid <= w_ser_valid;
      r_sof       <= w_sof;
      r_eof       <= w_eof;
      r_crc_out   <= w_crc_out;
    end
  end

endmodule

// File: doc/crc_16_tx_framer.md
# crc_16_tx_framer

Parallel-in, serial-out frame transmitter that sits directly upstream of the serial CRC-16/BUYPASS checker path. It accepts one DATA_W-bit word per frame over a valid/ready handshake and shifts it out MSB-first as a 1-bit stream. It then appends the 16-bit CRC of that word, also MSB-first, so a downstream serial CRC engine cleared at start of frame ends at residue 16'h0000.

## Interface
- DATA_W, 32, payload width in bits; must be ≥ 1.
- CRC_POLY, 16'h8005, generator polynomial; non-reflected.
- CRC_INIT, 16'h0000, CRC register value at start of every frame; no output XOR.

- clk_i  input  1  single clock; all state changes on its rising edge.
- rst_i  input  1  reset, asynchronous, active-low; asserting it clears all state immediately.
- data_i  input  DATA_W  payload word; sampled only on the accept edge.
- valid_i  input  1  payload word valid.
- ready_o  output  1  block idle and able to accept a word.
- ser_o  output  1  serial bit: payload MSB-first, then CRC MSB-first.
- ser_valid_o  output  1  ser_o carries a frame bit this cycle.
- sof_o  output  1  high with the first payload bit only.
- eof_o  output  1  high with the last CRC bit only (crc bit 0).
- crc_o  output  16  CRC of the most recently completed payload; held until the next one.

## Operation
- States: IDLE, DATA, CRC.
- IDLE:
  - ready_o=1.
  - Accept happens on an edge where valid_i=1 and ready_o=1.
  - On accept: shift register ← data_i; crc register ← CRC_INIT; bit counter ← 0; go to DATA.
- DATA:
  - ser_o = current shift-register MSB.
  - Each edge folds that bit into the crc register: crc ← (bit ^ crc[15]) ? (crc<<1) ^ CRC_POLY : crc<<1. The shift register then moves left by one.
  - After DATA_W bits: crc_o ← final crc, CRC shift register ← final crc; go to CRC.
- CRC:
  - ser_o = CRC shift-register MSB for 16 cycles.
  - After the 16th bit, go to IDLE.
- ready_o is high only in IDLE.
- valid_i while busy is ignored and data_i is not captured. Upstream holds valid_i/data_i until accepted.
- A word is never dropped or duplicated. There is exactly one frame per accept.
- All outputs other than ready_o are registered. ready_o is a decode of the state register and does not depend on valid_i combinationally.

## Timing
- Reset values (while rst_i=0): state IDLE, ready_o=1, ser_o=0, ser_valid_o=0, sof_o=0, eof_o=0, crc_o=16'h0000, and all internal registers 0.
- Accept edge E:
  - The first payload bit appears on ser_o with ser_valid_o=1 and sof_o=1 in the cycle right after E (zero added latency).
- Frame length:
  - ser_valid_o stays high for exactly DATA_W+16 consecutive cycles with no gaps.
  - Payload bits occupy cycles 0..DATA_W-1.
  - CRC bits occupy cycles DATA_W..DATA_W+15.
  - eof_o is high only in cycle DATA_W+15.
- crc_o updates on the edge ending the last payload bit, so it is valid from the first CRC-bit cycle onward.
- The edge ending the eof_o cycle returns the block to IDLE, raising ready_o. The earliest next accept is that next edge.
  - Back-to-back frames therefore have exactly 1 cycle with ser_valid_o=0 between them.
  - Minimum frame period is DATA_W+17 cycles.
- DATA_W=1: one payload cycle with sof_o=1, then 16 CRC cycles.
- Reset mid-frame:
  - The frame is aborted at once: ser_valid_o, sof_o and eof_o drop asynchronously.
  - crc_o returns to 0.
  - After release, the block is in IDLE with ready_o=1.
  - No partial CRC is emitted.

## Test plan
- Reset values: hold rst_i=0 for 3 cycles, then release -> ready_o=1, ser_valid_o=0, sof_o=0, eof_o=0, crc_o=16'h0000.
- Known vector: DATA_W=32, data_i=32'h00000001 -> 31 zeros then 1 on ser_o, followed by CRC bits 16'h8005 MSB-first. crc_o=16'h8005 and eof_o is high on cycle 47 only.
- Check value: DATA_W=72, data_i=72'h313233343536373839 ("123456789") -> appended CRC and crc_o are 16'hFEE8.
- Residue, 100 random 32-bit words: feed every 48-bit ser_o stream (ser_valid_o cycles only) through a bench CRC model starting at 16'h0000 -> final value 16'h0000. crc_o must also match the bench model of the payload.
- Handshake: valid_i held high continuously with a new word after each accept -> one frame per word in order, a 1-cycle ser_valid_o gap between frames, and data_i changes during busy cycles are never captured.
- Reset mid-frame: assert rst_i during payload bit 10 of a frame -> ser_valid_o=0 in that cycle. After release, a new word 32'hA5A5A5A5 produces a complete, correct 48-bit frame with sof_o on its first bit.
